// File: rtl/jtframe_dwnld_pack_pkg.sv
// Shared types for the download packer: FSM states, FIFO entry layout and SDRAM lane masks.
package jtframe_dwnld_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_e;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } fifo_entry_t;

  // prog_mask is active-low: the cleared bit selects the written lane
  localparam logic [1:0] LANE_LO = 2'b10;
  localparam logic [1:0] LANE_HI = 2'b01;

  function automatic logic [15:0] dup_byte(input logic [7:0] b);
    return {b, b};
  endfunction

endpackage

// File: rtl/jtframe_dwnld_pack_if.sv
// SDRAM programming bus: the packer is the master, the SDRAM controller the slave.
interface jtframe_dwnld_pack_if #(
  parameter int SDRAMW = 23
);
  logic [SDRAMW-1:0] prog_addr;
  logic [15:0]       prog_data;
  logic [1:0]        prog_mask;
  logic [1:0]        prog_ba;
  logic              prog_we;
  logic              prog_ack;
  logic              prog_rdy;
  logic              prom_we;

  modport master (
    output prog_addr, prog_data, prog_mask, prog_ba, prog_we, prom_we,
    input  prog_ack, prog_rdy
  );

  modport slave (
    input  prog_addr, prog_data, prog_mask, prog_ba, prog_we, prom_we,
    output prog_ack, prog_rdy
  );
endinterface

// File: rtl/jtframe_dwnld_pack_fifo.sv
// Synchronous FIFO of {addr,byte} entries; a push into a full FIFO is taken
// only when a pop happens in the same cycle.
module jtframe_dwnld_fifo
  import jtframe_dwnld_pkg::*;
#(
  parameter int AW = 2
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  fifo_entry_t din_i,
  input  logic        pop_i,
  output fifo_entry_t dout_o,
  output logic        full_o,
  output logic        empty_o
);
  localparam int DEPTH = 1 << AW;

  fifo_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          wr_en, rd_en;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign wr_en   = push_i & (~full_o | pop_i);
  assign rd_en   = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // NOTE: storage has no reset; cnt_q alone marks entries valid, so a reset
  // only needs to clear the pointers and the count.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/jtframe_dwnld_pack.sv
// Packs the ioctl byte stream into SDRAM bank writes and PROM strobes.
// Optional header skipping is enabled with the JTFRAME_DWNLD_HEADER_EN macro.
module jtframe_dwnld_pack
  import jtframe_dwnld_pkg::*;
#(
  parameter int          SDRAMW     = 23,
  parameter logic [24:0] BA1_START  = 25'h10_0000,
  parameter logic [24:0] BA2_START  = 25'h20_0000,
  parameter logic [24:0] BA3_START  = 25'h30_0000,
  parameter logic [24:0] PROM_START = 25'h1FF_FFFF,
  parameter int          HEADER     = 0,
  parameter int          FIFO_AW    = 2
)(
  input  logic                        clk_rom,
  input  logic                        rst,
  input  logic                        downloading,
  input  logic [24:0]                 ioctl_addr,
  input  logic [7:0]                  ioctl_dout,
  input  logic                        ioctl_wr,
  jtframe_dwnld_pack_if.master        prog,
  output logic                        dwnld_busy,
  output logic                        overflow
);
  localparam int OW = SDRAMW + 1;

  if (HEADER < 0 || BA1_START[0] || BA2_START[0] || BA3_START[0] ||
      BA2_START < BA1_START || BA3_START < BA2_START) begin : g_bad_params
    $error("jtframe_dwnld_pack: invalid HEADER or bank start parameters");
  end

  state_e            state_q, state_d;
  logic [24:0]       eff_addr;
  logic              wr_ok, is_prom, push_req, prom_req;
  logic              fifo_full, fifo_empty, fifo_pop, fifo_drop;
  fifo_entry_t       fifo_head;
  logic              prom_go, prom_from_reg, prom_load, prom_drop;
  logic              prom_pend_q;
  logic [24:0]       prom_addr_q, prom_sel_addr;
  logic [7:0]        prom_byte_q, prom_sel_byte;
  logic [SDRAMW-1:0] prom_off;
  logic [1:0]        head_ba;
  logic [24:0]       bank_start;
  logic [OW-1:0]     head_off;
  logic [SDRAMW-1:0] prog_addr_q, prog_addr_d;
  logic [15:0]       prog_data_q, prog_data_d;
  logic [1:0]        prog_mask_q, prog_mask_d;
  logic [1:0]        prog_ba_q, prog_ba_d;
  logic              prom_we_q, overflow_q;

`ifdef JTFRAME_DWNLD_HEADER_EN
  logic        dl_q, in_hdr;
  logic [31:0] hdr_cnt_q, hdr_cnt_d, hdr_base;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hdr_base  = (downloading && !dl_q) ? '0 : hdr_cnt_q;
    in_hdr    = hdr_base < 32'(HEADER);
    hdr_cnt_d = hdr_base;
    if (ioctl_wr && downloading && in_hdr) hdr_cnt_d = hdr_base + 32'd1;
  end

  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      dl_q      <= 1'b0;
      hdr_cnt_q <= '0;
    end else begin
      dl_q      <= downloading;
      hdr_cnt_q <= hdr_cnt_d;
    end
  end

  assign wr_ok    = ioctl_wr & downloading & ~in_hdr;
  assign eff_addr = ioctl_addr - 25'(HEADER);
`else
  assign wr_ok    = ioctl_wr & downloading;
  assign eff_addr = ioctl_addr;
`endif

  assign is_prom  = eff_addr >= PROM_START;
  assign push_req = wr_ok & ~is_prom;
  assign prom_req = wr_ok & is_prom;

  jtframe_dwnld_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk     (clk_rom),
    .rst     (rst),
    .push_i  (push_req),
    .din_i   ('{addr: eff_addr, data: ioctl_dout}),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A held PROM byte goes first, then a fresh PROM byte, then the FIFO head.
  always_comb begin
    state_d       = state_q;
    fifo_pop      = 1'b0;
    prom_go       = 1'b0;
    prom_from_reg = 1'b0;
    case (state_q)
      IDLE: begin
        if (prom_pend_q) begin
          prom_go       = 1'b1;
          prom_from_reg = 1'b1;
        end else if (prom_req) begin
          prom_go = 1'b1;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = REQ;
        end
      end
      REQ:     if (prog.prog_ack) state_d = prog.prog_rdy ? IDLE : WAIT;
      WAIT:    if (prog.prog_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the clock edge.
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    head_ba    = 2'd0;
    bank_start = '0;
    if (fifo_head.addr >= BA3_START) begin
      head_ba    = 2'd3;
      bank_start = BA3_START;
    end else if (fifo_head.addr >= BA2_START) begin
      head_ba    = 2'd2;
      bank_start = BA2_START;
    end else if (fifo_head.addr >= BA1_START) begin
      head_ba    = 2'd1;
      bank_start = BA1_START;
    end
    head_off = OW'(fifo_head.addr - bank_start);
  end

  assign prom_sel_addr = prom_from_reg ? prom_addr_q : eff_addr;
  assign prom_sel_byte = prom_from_reg ? prom_byte_q : ioctl_dout;
  assign prom_off      = SDRAMW'(prom_sel_addr - PROM_START);

  always_comb begin
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    prog_mask_d = prog_mask_q;
    prog_ba_d   = prog_ba_q;
    if (prom_go) begin
      prog_addr_d = prom_off;
      prog_data_d = dup_byte(prom_sel_byte);
    end else if (fifo_pop) begin
      prog_addr_d = head_off[OW-1:1];
      prog_data_d = dup_byte(fifo_head.data);
      prog_mask_d = head_off[0] ? LANE_HI : LANE_LO;
      prog_ba_d   = head_ba;
    end
  end

  assign fifo_drop = push_req & fifo_full & ~fifo_pop;
  assign prom_drop = prom_req & prom_pend_q;
  assign prom_load = prom_req & ~prom_pend_q & ~prom_go;

  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      prog_addr_q <= '0;
      prog_data_q <= '0;
      prog_mask_q <= '0;
      prog_ba_q   <= '0;
      prom_we_q   <= 1'b0;
      prom_pend_q <= 1'b0;
      prom_addr_q <= '0;
      prom_byte_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      prog_mask_q <= prog_mask_d;
      prog_ba_q   <= prog_ba_d;
      prom_we_q   <= prom_go;
      if (prom_load) begin
        prom_pend_q <= 1'b1;
        prom_addr_q <= eff_addr;
        prom_byte_q <= ioctl_dout;
      end else if (prom_from_reg) begin
        prom_pend_q <= 1'b0;
      end
      if (fifo_drop || prom_drop) overflow_q <= 1'b1;
    end
  end

  assign prog.prog_addr = prog_addr_q;
  assign prog.prog_data = prog_data_q;
  assign prog.prog_mask = prog_mask_q;
  assign prog.prog_ba   = prog_ba_q;
  assign prog.prog_we   = (state_q == REQ);
  assign prog.prom_we   = prom_we_q;

  assign dwnld_busy = downloading | ~fifo_empty | (state_q != IDLE) | prom_pend_q;
  assign overflow   = overflow_q;

endmodule
